ac_motor_vector_capture: RTL



---
 rtl/ac_motor_vector_capture_pkg.sv | 42 ++++
 rtl/ac_motor_vector_capture_if.sv | 30 +++
 rtl/ac_motor_vector_capture_counter.sv | 37 +++
 rtl/ac_motor_vector_capture.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ac_motor_vector_capture_pkg.sv
// Shared definitions for the vector-control PWM path: the period timing
// shared with the generator, the counter width, and the phase-code ranks.
package ac_motor_vector_pkg;

  // Clock and sampling frequency shared with the vector-control generator
  localparam int F_CLK       = 100_000_000;
  localparam int F_TAST      = 5_000;
  localparam int TAST_PERIOD = F_CLK / F_TAST;

  // Dwell counter and output width; holds PERIOD_LEN + LEN_TOL
  localparam int CNT_W = 15;

  // Ranks follow the order of the vectors inside one sampling period
  typedef enum logic [1:0] {
    RANK_LOW  = 2'd0,
    RANK_HIGH = 2'd1,
    RANK_ZERO = 2'd2
  } rank_e;

  // Phase lines packed as {u_0, u_high, u_low}; valid only when one-hot
  function automatic logic is_one_hot3(input logic [2:0] lines);
    logic result;
    case (lines)
      3'b001, 3'b010, 3'b100: result = 1'b1;
      default:                result = 1'b0;
    endcase
    return result;
  endfunction

  // Rank of a one-hot phase code; callers qualify with is_one_hot3
  function automatic rank_e rank_of(input logic [2:0] lines);
    rank_e result;
    case (lines)
      3'b001:  result = RANK_LOW;
      3'b010:  result = RANK_HIGH;
      3'b100:  result = RANK_ZERO;
      default: result = RANK_LOW;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ac_motor_vector_capture_if.sv
// Phase-line and dwell-report bundle between the PWM side and the capture.
interface ac_motor_vector_capture_if;
  import ac_motor_vector_pkg::*;

  // Phase-state lines from the vector-control generator
  logic             U_0;
  logic             U_LOW;
  logic             U_HIGH;

  // Dwell report of the last closed frame
  logic [CNT_W-1:0] T_LOW;
  logic [CNT_W-1:0] T_HIGH;
  logic [CNT_W-1:0] T_ZERO;
  logic             VALID;
  logic             ERR_LEN;
  logic             ERR_CODING;

  // Generator / telemetry side: drives phase lines, receives the report
  modport master (
    output U_0, U_LOW, U_HIGH,
    input  T_LOW, T_HIGH, T_ZERO, VALID, ERR_LEN, ERR_CODING
  );

  // Capture side: receives phase lines, drives the report
  modport slave (
    input  U_0, U_LOW, U_HIGH,
    output T_LOW, T_HIGH, T_ZERO, VALID, ERR_LEN, ERR_CODING
  );

endinterface

// File: rtl/ac_motor_vector_capture_counter.sv
// Saturating dwell counter: clear to 0, load 1 (frame start), increment, hold.
module vector_dwell_counter
  import ac_motor_vector_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_C = {W{1'b1}};

  logic [W-1:0] count_r;

  // Counter state: clear beats load, load beats increment, saturate at max
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (load1) begin
      count_r <= ONE_C;
    end else if (inc && (count_r != MAX_C)) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ac_motor_vector_capture.sv
// Readback monitor for the vector-control PWM: measures per-frame dwell
// times of the low, high and zero vectors from the one-hot phase lines.
// A frame closes on a rank regression (new period begins) or on timeout.
module ac_motor_vector_capture #(
  parameter int F_CLK       = ac_motor_vector_pkg::F_CLK,
  parameter int F_TAST      = ac_motor_vector_pkg::F_TAST,
  parameter int TAST_PERIOD = F_CLK / F_TAST,
  parameter int PERIOD_LEN  = TAST_PERIOD + 1,
  parameter int LEN_TOL     = 1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  ac_motor_vector_capture_if.slave  bus
);
  import ac_motor_vector_pkg::*;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Frame length window; reaching FRAME_MAX closes the frame by timeout
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(PERIOD_LEN + LEN_TOL);
  localparam logic [CNT_W-1:0] FRAME_MIN = CNT_W'(PERIOD_LEN - LEN_TOL);

  logic [0:0]       state_r;
  rank_e            rank_r;

  logic [2:0]       sample_s;
  logic             sample_valid_s;
  rank_e            sample_rank_s;
  logic             run_s;
  logic             timeout_s;
  logic             regress_s;
  logic             close_s;
  logic             start_s;
  logic             advance_s;
  logic             sel_low_s;
  logic             sel_high_s;
  logic             sel_zero_s;
  logic             err_len_s;

  logic [CNT_W-1:0] cnt_low_s;
  logic [CNT_W-1:0] cnt_high_s;
  logic [CNT_W-1:0] cnt_zero_s;
  logic [CNT_W-1:0] cnt_frame_s;

  logic [CNT_W-1:0] t_low_r;
  logic [CNT_W-1:0] t_high_r;
  logic [CNT_W-1:0] t_zero_r;
  logic             valid_r;
  logic             err_len_r;
  logic             err_coding_r;

  assign sample_s = {bus.U_0, bus.U_HIGH, bus.U_LOW};

  // Sample decode and frame control: when to close, start and advance
  always_comb begin
    sample_valid_s = is_one_hot3(sample_s);
    sample_rank_s  = rank_of(sample_s);
    run_s          = (state_r == ST_RUN);
    timeout_s      = (cnt_frame_s == FRAME_MAX);
    if (sample_valid_s) begin
      regress_s = (sample_rank_s < rank_r);
    end else begin
      regress_s = 1'b0;
    end
    close_s    = run_s && (timeout_s || regress_s);
    // A closing sample always opens the next frame, even when invalid
    start_s    = close_s || ((state_r == ST_IDLE) && sample_valid_s);
    advance_s  = run_s && !close_s;
    sel_low_s  = sample_valid_s && (sample_rank_s == RANK_LOW);
    sel_high_s = sample_valid_s && (sample_rank_s == RANK_HIGH);
    sel_zero_s = sample_valid_s && (sample_rank_s == RANK_ZERO);
    err_len_s  = (cnt_frame_s > FRAME_MAX) || (cnt_frame_s < FRAME_MIN);
  end

  vector_dwell_counter #(.W(CNT_W)) u_cnt_low (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (start_s && !sel_low_s),
    .load1 (start_s && sel_low_s),
    .inc   (advance_s && sel_low_s),
    .count (cnt_low_s)
  );

  vector_dwell_counter #(.W(CNT_W)) u_cnt_high (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (start_s && !sel_high_s),
    .load1 (start_s && sel_high_s),
    .inc   (advance_s && sel_high_s),
    .count (cnt_high_s)
  );

  vector_dwell_counter #(.W(CNT_W)) u_cnt_zero (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (start_s && !sel_zero_s),
    .load1 (start_s && sel_zero_s),
    .inc   (advance_s && sel_zero_s),
    .count (cnt_zero_s)
  );

  // Frame length counts every RUN cycle, including invalid samples
  vector_dwell_counter #(.W(CNT_W)) u_cnt_frame (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (1'b0),
    .load1 (start_s),
    .inc   (advance_s),
    .count (cnt_frame_s)
  );

  // FSM and current rank; invalid samples never change the rank
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      rank_r  <= RANK_LOW;
    end else begin
      if (start_s) begin
        state_r <= ST_RUN;
      end else begin
        state_r <= state_r;
      end
      if (sample_valid_s) begin
        rank_r <= sample_rank_s;
      end else begin
        rank_r <= rank_r;
      end
    end
  end

  // Registered report: latch the closed frame, pulse VALID / ERR_CODING
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      t_low_r      <= {CNT_W{1'b0}};
      t_high_r     <= {CNT_W{1'b0}};
      t_zero_r     <= {CNT_W{1'b0}};
      valid_r      <= 1'b0;
      err_len_r    <= 1'b0;
      err_coding_r <= 1'b0;
    end else begin
      valid_r      <= close_s;
      err_coding_r <= run_s && !sample_valid_s;
      if (close_s) begin
        t_low_r   <= cnt_low_s;
        t_high_r  <= cnt_high_s;
        t_zero_r  <= cnt_zero_s;
        err_len_r <= err_len_s;
      end else begin
        t_low_r   <= t_low_r;
        t_high_r  <= t_high_r;
        t_zero_r  <= t_zero_r;
        err_len_r <= err_len_r;
      end
    end
  end

  assign bus.T_LOW      = t_low_r;
  assign bus.T_HIGH     = t_high_r;
  assign bus.T_ZERO     = t_zero_r;
  assign bus.VALID      = valid_r;
  assign bus.ERR_LEN    = err_len_r;
  assign bus.ERR_CODING = err_coding_r;

endmodule
